fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the control decoder.
- Holds the PC and issues one outstanding instruction-memory request at a time over a req/ack handshake.
- Registers the returned 32-bit word and presents it, with op/rs/rt/rd/imm fields already split out, to decode/control under a valid/ready handshake.
- Accepts taken-branch/jump redirects from the branch path; squashes wrong-path fetches.

---
 rtl/fetch_stage_if.sv | 53 +++++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_stage_if                                         |
// | Description : Instruction-memory, redirect and decode handshakes of  |
// |               the fetch stage (perf taps with FETCH_PERF_EN).        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface fetch_stage_if #(
    parameter int AW = 32
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          id_ready;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_squashed;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  branch_taken, branch_target,
        input  id_ready,
        output instr_valid, instr, instr_pc, op, rs, rt, rd, imm
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_squashed
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output branch_taken, branch_target,
        output id_ready,
        input  instr_valid, instr, instr_pc, op, rs, rt, rd, imm
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_squashed
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_stage                                            |
// | Description : PC holder issuing one outstanding imem request, with   |
// |               redirect squash; FETCH_PERF_EN adds perf counters.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_stage #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_stage_if.master     bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          squash_q, squash_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic [AW-1:0] w_target;
    logic          w_deliver;
    logic          w_discard;

    assign w_target = bus.branch_target & ~AW'(3);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        valid_d    = valid_q;
        squash_d   = squash_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        w_deliver  = 1'b0;
        w_discard  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                if (bus.branch_taken) begin
                    pc_d   = w_target;
                    addr_d = w_target;
                end else begin
                    addr_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.branch_taken) begin
                        w_discard = 1'b1;
                        squash_d  = 1'b0;
                        pc_d      = w_target;
                        addr_d    = w_target;
                    end else if (squash_q) begin
                        // Wrong-path word: drop it and chase the redirected pc.
                        w_discard = 1'b1;
                        squash_d  = 1'b0;
                        addr_d    = pc_q;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = addr_q;
                        pc_d       = addr_q + AW'(4);
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = ST_FULL;
                    end
                end else if (bus.branch_taken) begin
                    // The memory still owes us this ack, so keep the request alive.
                    squash_d = 1'b1;
                    pc_d     = w_target;
                end
            end
            ST_FULL: begin
                if (bus.branch_taken) begin
                    w_discard = 1'b1;
                    valid_d   = 1'b0;
                    pc_d      = w_target;
                    addr_d    = w_target;
                    req_d     = 1'b1;
                    state_d   = ST_FETCH;
                end else if (bus.id_ready) begin
                    w_deliver = 1'b1;
                    valid_d   = 1'b0;
                    addr_d    = pc_q;
                    req_d     = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                valid_d  = 1'b0;
                squash_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q + 32'(w_deliver);
        perf_squashed_d = perf_squashed_q + 32'(w_discard);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign bus.perf_fetched  = perf_fetched_q;
    assign bus.perf_squashed = perf_squashed_q;
`endif

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.op          = instr_q[31:26];
    assign bus.rs          = instr_q[25:21];
    assign bus.rt          = instr_q[20:16];
    assign bus.rd          = instr_q[15:11];
    assign bus.imm         = instr_q[15:0];
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                         |
// | Description : Directed and random stimulus for fetch_stage against a |
// |               program-order reference model.                        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.AW(32)) bus ();
    fetch_stage_if #(.AW(32)) bus2 ();

    fetch_stage #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2C00_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // Second instance: zero-latency memory, always ready, never redirected.
    assign bus2.imem_ack      = bus2.imem_req;
    assign bus2.imem_rdata    = mem_word(bus2.imem_addr);
    assign bus2.branch_taken  = 1'b0;
    assign bus2.branch_target = 32'h0;
    assign bus2.id_ready      = 1'b1;

    // Reference model: the next program-order pc decode should see.
    logic [31:0] exp_pc;
    int          fetched_cnt, squashed_cnt;
    bit          dirty;
    bit          prev_req, prev_ack, prev_hold;
    logic [31:0] prev_addr;
    int          wait_cnt, lat, fixed_lat;
    bit          rand_mode;
    bit          drv_ready, drv_branch;
    logic [31:0] drv_target;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          ack;
        logic [31:0] w;
        @(posedge clk);
        #1;
        if (prev_req && !prev_ack) begin
            check("req_held", 32'(bus.imem_req), 32'd1);
            check("addr_held", bus.imem_addr, prev_addr);
        end
        if (prev_hold) check("valid_held", 32'(bus.instr_valid), 32'd1);
        check("no_req_when_full", 32'(bus.imem_req & bus.instr_valid), 32'd0);

        if (bus.imem_req && (!prev_req || prev_ack)) begin
            wait_cnt = 0;
            lat      = rand_mode ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (bus.imem_req) begin
            wait_cnt++;
        end
        ack = bus.imem_req && (wait_cnt >= lat);
        bus.imem_ack      = ack;
        bus.imem_rdata    = ack ? mem_word(bus.imem_addr) : $urandom;
        bus.id_ready      = drv_ready;
        bus.branch_taken  = drv_branch;
        bus.branch_target = drv_target;

        if (bus.instr_valid) begin
            w = mem_word(exp_pc);
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr", bus.instr, w);
            check("op", 32'(bus.op), 32'(w[31:26]));
            check("rs", 32'(bus.rs), 32'(w[25:21]));
            check("rt", 32'(bus.rt), 32'(w[20:16]));
            check("rd", 32'(bus.rd), 32'(w[15:11]));
            check("imm", 32'(bus.imm), 32'(w[15:0]));
        end

        if (ack && (dirty || drv_branch)) squashed_cnt++;
        if (ack) dirty = 1'b0;
        if (drv_branch && bus.imem_req && !ack) dirty = 1'b1;
        if (drv_branch && bus.instr_valid) squashed_cnt++;
        if (drv_branch) begin
            exp_pc = drv_target & ~32'd3;
        end else if (bus.instr_valid && drv_ready) begin
            exp_pc = exp_pc + 32'd4;
            fetched_cnt++;
        end

        prev_req   = bus.imem_req;
        prev_ack   = ack;
        prev_addr  = bus.imem_addr;
        prev_hold  = bus.instr_valid && !drv_ready && !drv_branch;
        drv_branch = 1'b0;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.imem_ack      = 1'b1;
        bus.imem_rdata    = 32'hDEAD_BEEF;
        bus.id_ready      = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_fields", {bus.op, bus.rs, bus.rt, bus.rd, bus.imm[10:0]}, 32'h0);
        check("rst_imm", 32'(bus.imm), 32'd0);
        check("rst2_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        check("rst2_req", 32'(bus2.imem_req), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", bus.perf_fetched, 32'd0);
        check("rst_perf_squashed", bus.perf_squashed, 32'd0);
`endif
        bus.imem_ack = 1'b0;
        rst_n        = 1'b1;
        exp_pc       = 32'h0;
        fetched_cnt  = 0;
        squashed_cnt = 0;
        dirty        = 1'b0;
        prev_req     = 1'b0;
        prev_ack     = 1'b0;
        prev_hold    = 1'b0;
        prev_addr    = 32'h0;
        wait_cnt     = 0;
        lat          = 0;
        drv_branch   = 1'b0;
        drv_target   = 32'h0;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!bus.instr_valid && n < max_cycles) begin
            cycle();
            n++;
        end
        check("valid_timeout", 32'(bus.instr_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rand_mode = 1'b0;
        fixed_lat = 0;
        drv_ready = 1'b1;
        do_reset();

        // Zero-latency memory, decode always ready.
        cycle();
        check("t1_req0", 32'(bus.imem_req), 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        check("t1_valid0", 32'(bus.instr_valid), 32'd0);
        check("t1b_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        cycle();
        check("t1_valid1", 32'(bus.instr_valid), 32'd1);
        check("t1_op11", 32'(bus.op), 32'd11);
        check("t1_instr", bus.instr, 32'h2C00_0000);
        check("t1_req_full", 32'(bus.imem_req), 32'd0);
        check("t1b_instr_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        cycle();
        check("t1_addr4", bus.imem_addr, 32'h4);
        check("t1_valid_gap", 32'(bus.instr_valid), 32'd0);
        check("t1b_wrap_addr", bus2.imem_addr, 32'h0);
        cycle();
        check("t1_instr_pc4", bus.instr_pc, 32'h4);
        cycle();
        check("t1_addr8", bus.imem_addr, 32'h8);

        // Reset lands while an ack is being offered.
        do_reset();

        // Latency 3, decode stalled for 5 cycles on the first instruction.
        fixed_lat = 3;
        drv_ready = 1'b0;
        wait_valid(20, n);
        check("t2_latency", 32'(n), 32'd5);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_hold_pc", bus.instr_pc, 32'h0);
            check("t2_hold_req", 32'(bus.imem_req), 32'd0);
        end
        drv_ready = 1'b1;
        cycle();
        cycle();
        check("t2_next_req", 32'(bus.imem_req), 32'd1);
        check("t2_next_addr", bus.imem_addr, 32'h4);

        // Redirect during FETCH, ack two cycles later.
        do_reset();
        fixed_lat  = 2;
        drv_ready  = 1'b1;
        drv_branch = 1'b1;
        drv_target = 32'h103;
        cycle();
        check("t3_addr_orig", bus.imem_addr, 32'h0);
        cycle();
        cycle();
        check("t3_no_valid", 32'(bus.instr_valid), 32'd0);
        cycle();
        check("t3_redirect_addr", bus.imem_addr, 32'h100);
        check("t3_squash_valid", 32'(bus.instr_valid), 32'd0);
        wait_valid(10, n);
        check("t3_instr_pc", bus.instr_pc, 32'h100);

        // Redirect coincident with ack, then redirect while FULL and stalled.
        do_reset();
        fixed_lat = 1;
        drv_ready = 1'b0;
        cycle();
        drv_branch = 1'b1;
        drv_target = 32'h40;
        cycle();
        cycle();
        check("t4_valid_drop", 32'(bus.instr_valid), 32'd0);
        check("t4_addr40", bus.imem_addr, 32'h40);
        wait_valid(10, n);
        check("t4_instr_pc40", bus.instr_pc, 32'h40);
        drv_branch = 1'b1;
        drv_target = 32'h80;
        cycle();
        cycle();
        check("t4_full_drop", 32'(bus.instr_valid), 32'd0);
        check("t4_addr80", bus.imem_addr, 32'h80);
        drv_ready = 1'b1;
        for (int i = 0; i < 40 && fetched_cnt < 3; i++) cycle();
        check("t4_fetched", 32'(fetched_cnt), 32'd3);
        check("t4_squashed", 32'(squashed_cnt), 32'd2);
        cycle();
`ifdef FETCH_PERF_EN
        check("t4_perf_fetched", bus.perf_fetched, 32'd3);
        check("t4_perf_squashed", bus.perf_squashed, 32'd2);
`endif
        do_reset();

        // Random latency, stalls and redirects against the reference model.
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            drv_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                drv_branch = 1'b1;
                drv_target = $urandom_range(0, 1023);
            end
            cycle();
        end
        drv_ready = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check("rand_progress", 32'(fetched_cnt > 30), 32'd1);
`ifdef FETCH_PERF_EN
        check("rand_perf_fetched", bus.perf_fetched, 32'(fetched_cnt));
        check("rand_perf_squashed", bus.perf_squashed, 32'(squashed_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
